// File: rtl/alarm_buzzer_driver_pkg.sv
// Shared types and elaboration-time helpers for the alarm buzzer driver.
package alarm_buzzer_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEEP  = 2'd1,
        ST_GAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    localparam int IDX_W = 4;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold 0..max_count; never narrower than 1.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/alarm_buzzer_driver_if.sv
// Level-only link between the PIO enable bit and the buzzer driver outputs.
interface alarm_buzzer_driver_if;
    // No handshake: enable is a level sampled every clock; outputs are levels
    // updated on the same edge. There is no valid/ready pairing on this link.
    logic                               enable;
    logic                               buzzer_out;
    logic                               active;
    logic [3:0]                         beep_idx;
    alarm_buzzer_driver_pkg::state_e    state;

    modport master (
        output enable,
        input  buzzer_out,
        input  active,
        input  beep_idx,
        input  state
    );

    modport slave (
        input  enable,
        output buzzer_out,
        output active,
        output beep_idx,
        output state
    );
endinterface

// File: rtl/alarm_buzzer_driver_tone_div.sv
// Half-period counter and tone flop; clear restarts the tone high, idle forces it low.
module alarm_buzzer_driver_tone_div
    import alarm_buzzer_driver_pkg::*;
#(
    parameter int HALF_CYC = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic run_i,
    output logic tone_o
);

    localparam int CNT_W = cnt_width(HALF_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;

    always_comb begin
        cnt_d  = '0;
        tone_d = 1'b0;
        if (clear_i) begin
            tone_d = 1'b1;
        end else if (run_i) begin
            if (cnt_q == CNT_W'(HALF_CYC - 1)) begin
                tone_d = ~tone_q;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                tone_d = tone_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone_o = tone_q;

endmodule

// File: rtl/alarm_buzzer_driver.sv
// Alarm cadence FSM: N tone beeps separated by gaps, then a pause, while enable is high.
module alarm_buzzer_driver
    import alarm_buzzer_driver_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TONE_HZ         = 2_000,
    parameter int ON_MS           = 100,
    parameter int OFF_MS          = 100,
    parameter int PAUSE_MS        = 500,
    parameter int BEEPS_PER_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alarm_buzzer_driver_if.slave bus
);

    localparam int HALF_CYC  = CLK_HZ / (2 * TONE_HZ);
    localparam int ON_CYC    = ms_to_cycles(CLK_HZ, ON_MS);
    localparam int OFF_CYC   = ms_to_cycles(CLK_HZ, OFF_MS);
    localparam int PAUSE_CYC = ms_to_cycles(CLK_HZ, PAUSE_MS);
    localparam int TMR_W     = cnt_width(max3(ON_CYC, OFF_CYC, PAUSE_CYC));

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEEPS_PER_BURST - 1);

    if (HALF_CYC < 1 || ON_CYC < 1 || OFF_CYC < 1 || PAUSE_CYC < 1) begin : g_bad_timing
        $error("alarm_buzzer_driver: a derived cycle count is below 1");
    end
    if (BEEPS_PER_BURST < 1 || BEEPS_PER_BURST > 15) begin : g_bad_beeps
        $error("alarm_buzzer_driver: BEEPS_PER_BURST must be 1..15");
    end

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               active_q;
    logic               tone_clear;
    logic               tone_run;
    logic               tone;

    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        idx_d      = idx_q;
        tone_clear = 1'b0;
        tone_run   = 1'b0;
        // Dropping enable wins over any timer expiry in every state.
        if (!bus.enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d    = ST_BEEP;
                    idx_d      = '0;
                    tone_clear = 1'b1;
                end
                ST_BEEP: begin
                    if (timer_q == TMR_W'(ON_CYC - 1)) begin
                        if (idx_q < LAST_IDX) begin
                            state_d = ST_GAP;
                            idx_d   = idx_q + IDX_W'(1);
                        end else begin
                            state_d = ST_PAUSE;
                        end
                    end else begin
                        timer_d  = timer_q + TMR_W'(1);
                        tone_run = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (timer_q == TMR_W'(OFF_CYC - 1)) begin
                        state_d    = ST_BEEP;
                        tone_clear = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (timer_q == TMR_W'(PAUSE_CYC - 1)) begin
                        state_d    = ST_BEEP;
                        idx_d      = '0;
                        tone_clear = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            active_q <= (state_d != ST_IDLE);
        end
    end

    alarm_buzzer_driver_tone_div #(
        .HALF_CYC (HALF_CYC)
    ) u_tone_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (tone_clear),
        .run_i   (tone_run),
        .tone_o  (tone)
    );

    assign bus.buzzer_out = tone;
    assign bus.active     = active_q;
    assign bus.beep_idx   = idx_q;
    assign bus.state      = state_q;

endmodule
